// File: rtl/reg_file_pkg.sv
// Shared defaults for the multi-port register file with pending-write scoreboard.
package reg_file_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;
  localparam int unsigned DefNumRd = 2;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-destination scoreboard: one pend bit per entry plus a registered population count.
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en_i,
  input  logic [ADDR_W-1:0]       set_addr_i,
  input  logic                    clr_en_i,
  input  logic [ADDR_W-1:0]       clr_addr_i,
  output logic [(2**ADDR_W)-1:0]  pend_o,
  output logic [ADDR_W:0]         cnt_o
);

  localparam int unsigned Depth = 2**ADDR_W;
  localparam logic [ADDR_W:0] CntOne = {{ADDR_W{1'b0}}, 1'b1};

  logic [Depth-1:0] pend_d, pend_q;
  logic [ADDR_W:0]  cnt_d, cnt_q;
  logic             inc, dec;

  // Set is applied after clear so a same-address reserve wins over a write.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
    if (set_en_i) pend_d[set_addr_i] = 1'b1;
  end

  assign inc = set_en_i && !pend_q[set_addr_i];
  assign dec = clr_en_i && pend_q[clr_addr_i] && !(set_en_i && (set_addr_i == clr_addr_i));

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !dec)      cnt_d = cnt_q + CntOne;
    else if (dec && !inc) cnt_d = cnt_q - CntOne;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pend_o = pend_q;
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with write-through bypass and a pending-write scoreboard.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_pend,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  output logic [ADDR_W:0]            pend_cnt,
  output logic                       wr_orphan
);

  localparam int unsigned Depth = 2**ADDR_W;

  logic [DATA_W-1:0] mem_q [Depth];
  logic [Depth-1:0]  pend;
  logic              wr_live, rsv_live;
  logic              orphan_d, orphan_q;

  // Strobes to a zero-forced entry are dropped here so neither storage nor scoreboard sees them.
  assign wr_live  = wr_en  && !(ZERO_REG && (wr_addr == '0));
  assign rsv_live = rsv_en && !(ZERO_REG && (rsv_addr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (wr_live) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (rsv_live),
    .set_addr_i (rsv_addr),
    .clr_en_i   (wr_live),
    .clr_addr_i (wr_addr),
    .pend_o     (pend),
    .cnt_o      (pend_cnt)
  );

  assign orphan_d = wr_live && !pend[wr_addr] && !(rsv_live && (rsv_addr == wr_addr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) orphan_q <= 1'b0;
    else      orphan_q <= orphan_d;
  end

  assign wr_orphan = orphan_q;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              zero, hit;

    assign addr = rd_addr[i*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG && (addr == '0);
    // wr_live already excludes zero-forced writes, so hit never fires on a forced entry.
    assign hit  = wr_live && (wr_addr == addr);

    assign rd_data[i*DATA_W +: DATA_W] = zero ? '0 : (hit ? wr_data : mem_q[addr]);
    assign rd_pend[i] = pend[addr] && !hit;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Randomized and directed checks of reg_file_mp against an array-based reference model.
module tb_reg_file_mp;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NR    = 2;
  localparam int DEPTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_pend;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_en;
  logic [AW-1:0]    rsv_addr;
  logic [AW:0]      pend_cnt;
  logic             wr_orphan;

  int n_checks = 0;
  int n_fail   = 0;

  reg_file_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_pend   (rd_pend),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .pend_cnt  (pend_cnt),
    .wr_orphan (wr_orphan)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: storage contents, pending set, and last-cycle orphan flag.
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_pend [DEPTH];
  bit            m_orphan;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  <= '0;
        m_pend[i] <= 1'b0;
      end
      m_orphan <= 1'b0;
    end else begin
      m_orphan <= wr_en && (wr_addr != 0) && !m_pend[wr_addr] &&
                  !(rsv_en && rsv_addr == wr_addr);
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr]  <= wr_data;
        m_pend[wr_addr] <= 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] <= 1'b1;
    end
  end

  function automatic logic [DW-1:0] exp_data(input int a);
    if (a == 0) return '0;
    if (wr_en && int'(wr_addr) == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_pend(input int a);
    return (a != 0) && m_pend[a] && !(wr_en && int'(wr_addr) == a);
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  always @(negedge clk) begin
    for (int p = 0; p < NR; p++) begin
      int a;
      a = int'(rd_addr[p*AW +: AW]);
      check($sformatf("model rd_data[%0d] addr %0d", p, a), 64'(rd_data[p*DW +: DW]),
            64'(exp_data(a)));
      check($sformatf("model rd_pend[%0d] addr %0d", p, a), 64'(rd_pend[p]),
            64'(exp_pend(a)));
    end
    check("model pend_cnt", 64'(pend_cnt), 64'(exp_cnt()));
    check("model wr_orphan", 64'(wr_orphan), 64'(m_orphan));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    rsv_en = 1'b0;
  endtask

  task automatic rd(input int p, input int a);
    rd_addr[p*AW +: AW] = a[AW-1:0];
  endtask

  initial begin
    rst      = 1'b0;
    rd_addr  = '0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    #3;
    check("reset pend_cnt", 64'(pend_cnt), 64'd0);
    check("reset wr_orphan", 64'(wr_orphan), 64'd0);
    #10 rst = 1'b1;

    for (int a = 0; a < DEPTH; a++) begin
      rd(0, a);
      rd(1, DEPTH - 1 - a);
      #1;
      check("post-reset rd_data0", 64'(rd_data[DW-1:0]), 64'd0);
      check("post-reset rd_data1", 64'(rd_data[2*DW-1:DW]), 64'd0);
      check("post-reset rd_pend", 64'(rd_pend), 64'd0);
      check("post-reset pend_cnt", 64'(pend_cnt), 64'd0);
    end

    step(); wr_en = 1'b1; wr_addr = 5'd15; wr_data = 32'h0000_0064;
    step(); idle(); rd(0, 15);
    #1 check("r15 readback", 64'(rd_data[DW-1:0]), 64'h64);

    step(); wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF; rd(0, 3); rd(1, 3);
    #1 check("bypass r3 port0", 64'(rd_data[DW-1:0]), 64'hDEAD_BEEF);
    check("bypass r3 port1", 64'(rd_data[2*DW-1:DW]), 64'hDEAD_BEEF);

    step(); wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h5; rd(0, 0); rd(1, 0);
    #1 check("r0 same-cycle", 64'(rd_data[DW-1:0]), 64'd0);
    step(); idle();
    #1 check("r0 after write", 64'(rd_data[DW-1:0]), 64'd0);
    check("r0 pend", 64'(rd_pend[1]), 64'd0);

    step(); rsv_en = 1'b1; rsv_addr = 5'd7;
    step(); idle(); rd(0, 7);
    #1 check("rsv r7 rd_pend", 64'(rd_pend[0]), 64'd1);
    check("rsv r7 pend_cnt", 64'(pend_cnt), 64'd1);
    step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
    #1 check("wr r7 bypass pend", 64'(rd_pend[0]), 64'd0);
    check("wr r7 bypass data", 64'(rd_data[DW-1:0]), 64'h77);
    step(); idle();
    #1 check("wr r7 cleared pend", 64'(rd_pend[0]), 64'd0);
    check("wr r7 pend_cnt", 64'(pend_cnt), 64'd0);
    check("wr r7 not orphan", 64'(wr_orphan), 64'd0);

    step(); rsv_en = 1'b1; rsv_addr = 5'd7;
    step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h1;
    step(); idle();
    #1 check("rsv+wr r7 rd_pend", 64'(rd_pend[0]), 64'd1);
    check("rsv+wr r7 pend_cnt", 64'(pend_cnt), 64'd1);
    step(); wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h2;
    step(); idle();
    #1 check("r7 drained pend_cnt", 64'(pend_cnt), 64'd0);

    step(); wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h9; rd(0, 9);
    step(); idle();
    #1 check("orphan r9 set", 64'(wr_orphan), 64'd1);
    step();
    #1 check("orphan r9 one cycle", 64'(wr_orphan), 64'd0);

    step(); rsv_en = 1'b1; rsv_addr = 5'd5;
    step();
    step(); idle();
    #1 check("double rsv r5 pend_cnt", 64'(pend_cnt), 64'd1);

    for (int a = 0; a < DEPTH; a++) begin
      step(); rsv_en = 1'b1; rsv_addr = a[AW-1:0];
    end
    step(); idle(); rd(0, 0); rd(1, 30);
    #1 check("full pend_cnt", 64'(pend_cnt), 64'd31);
    check("full r0 pend", 64'(rd_pend[0]), 64'd0);
    check("full r30 pend", 64'(rd_pend[1]), 64'd1);
    step(); rsv_en = 1'b1; rsv_addr = 5'd31;
    step(); idle();
    #1 check("full re-rsv pend_cnt", 64'(pend_cnt), 64'd31);

    step(); wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'hABCD; rsv_en = 1'b1;
    rsv_addr = 5'd12; rd(0, 11); rd(1, 30);
    #2 rst = 1'b0;
    #1 check("mid reset pend_cnt", 64'(pend_cnt), 64'd0);
    check("mid reset wr_orphan", 64'(wr_orphan), 64'd0);
    check("mid reset bypass", 64'(rd_data[DW-1:0]), 64'hABCD);
    check("mid reset r30 data", 64'(rd_data[2*DW-1:DW]), 64'd0);
    check("mid reset r30 pend", 64'(rd_pend[1]), 64'd0);
    @(posedge clk); #1;
    idle(); rst = 1'b1; rd(1, 12);
    #1 check("reset discards write", 64'(rd_data[DW-1:0]), 64'd0);
    step();
    #1 check("reset discards reserve", 64'(pend_cnt), 64'd0);
    check("reset discards r12 pend", 64'(rd_pend[1]), 64'd0);

    for (int c = 0; c < 4000; c++) begin
      step();
      if (!rst) rst = 1'b1;
      wr_en    = ($urandom_range(0, 9) < 4);
      rsv_en   = ($urandom_range(0, 9) < 6);
      wr_data  = $urandom;
      wr_addr  = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rsv_addr = $urandom_range(0, 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      for (int p = 0; p < NR; p++) begin
        rd(p, $urandom_range(0, 1) ? int'(wr_addr) : int'($urandom_range(0, 31)));
      end
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
      end
    end

    step(); idle();
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
